// File: rtl/memstage.sv
`default_nettype none

// ============================================================================
// Module   : memstage (with riscv_pkg)
// Purpose  : rv32i memory-access stage. Issues loads/stores over a
//            req/gnt/rvalid handshake, aligns/extends load data and presents
//            a one-cycle-valid writeback result. Non-memory ops pass through
//            with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================

package riscv_pkg;
    typedef logic [31:0] instruction_t;
endpackage

module memstage (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  riscv_pkg::instruction_t instruction_i,
    input  logic [31:0]             alu_result_i,
    input  logic [31:0]             store_data_i,
    input  logic                    load_i,
    input  logic                    store_i,
    input  logic [2:0]              funct3_i,
    input  logic [4:0]              rd_i,
    input  logic                    reg_write_i,
    output logic                    dmem_req_o,
    output logic                    dmem_we_o,
    output logic [31:0]             dmem_addr_o,
    output logic [3:0]              dmem_be_o,
    output logic [31:0]             dmem_wdata_o,
    input  logic                    dmem_gnt_i,
    input  logic                    dmem_rvalid_i,
    input  logic [31:0]             dmem_rdata_i,
    output logic                    valid_o,
    output riscv_pkg::instruction_t instruction_o,
    output logic [31:0]             data_o,
    output logic [4:0]              rd_o,
    output logic                    reg_write_o,
    output logic                    fault_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    state_e                  state_q,      state_d;

    // Latched memory transaction (held stable while the request is pending)
    logic                    mem_we_q,     mem_we_d;
    logic [31:0]             mem_addr_q,   mem_addr_d;
    logic [31:0]             mem_wdata_q,  mem_wdata_d;
    logic [3:0]              mem_be_q,     mem_be_d;
    logic [2:0]              mem_funct3_q, mem_funct3_d;
    logic [4:0]              mem_rd_q,     mem_rd_d;
    logic                    mem_regw_q,   mem_regw_d;
    riscv_pkg::instruction_t mem_instr_q,  mem_instr_d;

    // Writeback result registers
    logic                    res_valid_q,  res_valid_d;
    logic                    res_fault_q,  res_fault_d;
    logic [31:0]             res_data_q,   res_data_d;
    logic [4:0]              res_rd_q,     res_rd_d;
    logic                    res_regw_q,   res_regw_d;
    riscv_pkg::instruction_t res_instr_q,  res_instr_d;

    logic                    w_fault;
    logic [3:0]              w_st_be;
    logic [31:0]             w_st_wdata;
    logic [31:0]             w_ld_data;
    logic [7:0]              w_ld_byte;
    logic [15:0]             w_ld_half;

    // Fault detection and store lane formatting from the incoming instruction
    always_comb begin
        logic w_misalign;
        logic w_bad_f3;
        w_misalign = ((funct3_i[1:0] == 2'b01) && alu_result_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00));
        // Stores only know B/H/W; loads additionally allow BU/HU
        if (store_i) begin
            w_bad_f3 = funct3_i[2] || (funct3_i[1:0] == 2'b11);
        end else begin
            w_bad_f3 = (funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110);
        end
        w_fault = w_misalign || w_bad_f3;

        case (funct3_i[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << alu_result_i[1:0];
                w_st_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                w_st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = store_data_i;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the latched access
    always_comb begin
        case (mem_addr_q[1:0])
            2'b00:   w_ld_byte = dmem_rdata_i[7:0];
            2'b01:   w_ld_byte = dmem_rdata_i[15:8];
            2'b10:   w_ld_byte = dmem_rdata_i[23:16];
            default: w_ld_byte = dmem_rdata_i[31:24];
        endcase
        w_ld_half = mem_addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (mem_funct3_q)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = dmem_rdata_i;
        endcase
    end

    // Next-state logic: accept, issue, complete
    always_comb begin
        state_d      = state_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        mem_funct3_d = mem_funct3_q;
        mem_rd_d     = mem_rd_q;
        mem_regw_d   = mem_regw_q;
        mem_instr_d  = mem_instr_q;
        res_valid_d  = 1'b0;
        res_fault_d  = res_fault_q;
        res_data_d   = res_data_q;
        res_rd_d     = res_rd_q;
        res_regw_d   = res_regw_q;
        res_instr_d  = res_instr_q;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (!(load_i || store_i) || w_fault) begin
                        // Pass-through, or a faulting access reported without
                        // touching memory (data carries the faulting address)
                        res_valid_d = 1'b1;
                        res_fault_d = load_i || store_i;
                        res_data_d  = alu_result_i;
                        res_rd_d    = rd_i;
                        res_regw_d  = reg_write_i && !(load_i || store_i);
                        res_instr_d = instruction_i;
                    end else begin
                        mem_we_d     = store_i;
                        mem_addr_d   = alu_result_i;
                        mem_wdata_d  = store_i ? w_st_wdata : 32'd0;
                        mem_be_d     = store_i ? w_st_be : 4'b0000;
                        mem_funct3_d = funct3_i;
                        mem_rd_d     = rd_i;
                        mem_regw_d   = reg_write_i;
                        mem_instr_d  = instruction_i;
                        state_d      = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    if (mem_we_q) begin
                        res_valid_d = 1'b1;
                        res_fault_d = 1'b0;
                        res_data_d  = mem_addr_q;
                        res_rd_d    = mem_rd_q;
                        res_regw_d  = 1'b0;
                        res_instr_d = mem_instr_q;
                        state_d     = S_IDLE;
                    end else begin
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    res_valid_d = 1'b1;
                    res_fault_d = 1'b0;
                    res_data_d  = w_ld_data;
                    res_rd_d    = mem_rd_q;
                    res_regw_d  = mem_regw_q;
                    res_instr_d = mem_instr_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_be_q     <= 4'b0000;
            mem_funct3_q <= 3'd0;
            mem_rd_q     <= 5'd0;
            mem_regw_q   <= 1'b0;
            mem_instr_q  <= '0;
            res_valid_q  <= 1'b0;
            res_fault_q  <= 1'b0;
            res_data_q   <= 32'd0;
            res_rd_q     <= 5'd0;
            res_regw_q   <= 1'b0;
            res_instr_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            mem_funct3_q <= mem_funct3_d;
            mem_rd_q     <= mem_rd_d;
            mem_regw_q   <= mem_regw_d;
            mem_instr_q  <= mem_instr_d;
            res_valid_q  <= res_valid_d;
            res_fault_q  <= res_fault_d;
            res_data_q   <= res_data_d;
            res_rd_q     <= res_rd_d;
            res_regw_q   <= res_regw_d;
            res_instr_q  <= res_instr_d;
        end
    end

    assign ready_o       = (state_q == S_IDLE);
    assign dmem_req_o    = (state_q == S_REQ);
    assign dmem_we_o     = mem_we_q;
    assign dmem_addr_o   = {mem_addr_q[31:2], 2'b00};
    assign dmem_be_o     = mem_be_q;
    assign dmem_wdata_o  = mem_wdata_q;
    assign valid_o       = res_valid_q;
    assign fault_o       = res_fault_q;
    assign data_o        = res_data_q;
    assign rd_o          = res_rd_q;
    assign reg_write_o   = res_regw_q;
    assign instruction_o = res_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_memstage.sv
`default_nettype none

// ============================================================================
// Module   : tb_memstage
// Purpose  : Self-checking bench for memstage: directed vectors plus a
//            cycle-level behavioural model compared on every clock.
// Revision : 1.0 - initial release
// ============================================================================

module tb_memstage;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    valid_i;
    logic                    ready_o;
    riscv_pkg::instruction_t instruction_i;
    logic [31:0]             alu_result_i;
    logic [31:0]             store_data_i;
    logic                    load_i;
    logic                    store_i;
    logic [2:0]              funct3_i;
    logic [4:0]              rd_i;
    logic                    reg_write_i;
    logic                    dmem_req_o;
    logic                    dmem_we_o;
    logic [31:0]             dmem_addr_o;
    logic [3:0]              dmem_be_o;
    logic [31:0]             dmem_wdata_o;
    logic                    dmem_gnt_i;
    logic                    dmem_rvalid_i;
    logic [31:0]             dmem_rdata_i;
    logic                    valid_o;
    riscv_pkg::instruction_t instruction_o;
    logic [31:0]             data_o;
    logic [4:0]              rd_o;
    logic                    reg_write_o;
    logic                    fault_o;

    memstage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instruction_i(instruction_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .load_i(load_i), .store_i(store_i),
        .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .valid_o(valid_o), .instruction_o(instruction_o), .data_o(data_o),
        .rd_o(rd_o), .reg_write_o(reg_write_o), .fault_o(fault_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference (spec rules, plain arithmetic)
    function automatic logic m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        if (st && (f3 > 3'd2)) return 1'b1;
        if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        nb = 1 << f3[1:0];
        return (int'(a[1:0]) % nb) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        nb = 1 << f3[1:0];
        return 4'(((1 << nb) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int nb;
        nb = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v, mask;
        int nb;
        nb = 1 << f3[1:0];
        if (nb >= 4) return w;
        v    = w >> (8 * a[1:0]);
        mask = (32'h1 << (8 * nb)) - 32'h1;
        v    = v & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Model state: expected outputs for the current cycle, plus the pending op
    logic        exp_valid, exp_fault, exp_rw, exp_data_known;
    logic [31:0] exp_data, exp_instr;
    logic [4:0]  exp_rd;
    logic        chk_en = 1'b0;
    logic        m_pend, m_gnt, m_st, m_rw;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_sdata, m_instr;
    logic [4:0]  m_rd;
    int          last_valid_cyc = -1;

    // Compare DUT against the model, then advance the model from the inputs
    initial begin
        forever begin
            @(negedge clk_i);
            if (chk_en) begin
                chk("valid_o", 32'(valid_o), 32'(exp_valid));
                chk("ready_o", 32'(ready_o), 32'(!m_pend));
                chk("dmem_req_o", 32'(dmem_req_o), 32'(m_pend && !m_gnt));
                if (m_pend && !m_gnt) begin
                    chk("dmem_we_o", 32'(dmem_we_o), 32'(m_st));
                    chk("dmem_addr_o", dmem_addr_o, m_addr & 32'hFFFF_FFFC);
                    chk("dmem_be_o", 32'(dmem_be_o), m_st ? 32'(m_be(m_f3, m_addr)) : 32'd0);
                    if (m_st) chk("dmem_wdata_o", dmem_wdata_o, m_wdata(m_f3, m_sdata));
                end
                if (exp_valid) begin
                    last_valid_cyc = cyc;
                    if (exp_data_known) chk("data_o", data_o, exp_data);
                    chk("rd_o", 32'(rd_o), 32'(exp_rd));
                    chk("reg_write_o", 32'(reg_write_o), 32'(exp_rw));
                    chk("fault_o", 32'(fault_o), 32'(exp_fault));
                    chk("instruction_o", instruction_o, exp_instr);
                end
            end
            exp_valid = 1'b0;
            if (rst_i) begin
                chk_en = 1'b1;
                m_pend = 1'b0; m_gnt = 1'b0; m_st = 1'b0; m_rw = 1'b0;
                m_f3 = 3'd0; m_addr = 32'd0; m_sdata = 32'd0; m_instr = 32'd0; m_rd = 5'd0;
                exp_fault = 1'b0; exp_rw = 1'b0; exp_data = 32'd0; exp_instr = 32'd0;
                exp_rd = 5'd0; exp_data_known = 1'b1;
            end else if (!m_pend) begin
                if (valid_i) begin
                    if (!(load_i || store_i) || m_fault(store_i, funct3_i, alu_result_i)) begin
                        exp_valid = 1'b1;
                        exp_fault = load_i || store_i;
                        exp_rw    = (load_i || store_i) ? 1'b0 : reg_write_i;
                        exp_data  = alu_result_i;
                        exp_data_known = 1'b1;
                        exp_rd    = rd_i;
                        exp_instr = instruction_i;
                    end else begin
                        m_pend = 1'b1; m_gnt = 1'b0; m_st = store_i; m_f3 = funct3_i;
                        m_addr = alu_result_i; m_sdata = store_data_i; m_rd = rd_i;
                        m_rw = reg_write_i; m_instr = instruction_i;
                    end
                end
            end else if (!m_gnt) begin
                if (dmem_gnt_i) begin
                    if (m_st) begin
                        exp_valid = 1'b1; exp_fault = 1'b0; exp_rw = 1'b0;
                        exp_data_known = 1'b0; exp_rd = m_rd; exp_instr = m_instr;
                        m_pend = 1'b0;
                    end else begin
                        m_gnt = 1'b1;
                    end
                end
            end else if (dmem_rvalid_i) begin
                exp_valid = 1'b1; exp_fault = 1'b0; exp_rw = m_rw;
                exp_data = m_load(m_f3, m_addr, dmem_rdata_i); exp_data_known = 1'b1;
                exp_rd = m_rd; exp_instr = m_instr;
                m_pend = 1'b0; m_gnt = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid_o"}, 32'(valid_o), 32'd0);
        chk({tag, ".ready_o"}, 32'(ready_o), 32'd1);
        chk({tag, ".req"}, 32'(dmem_req_o), 32'd0);
        chk({tag, ".we"}, 32'(dmem_we_o), 32'd0);
        chk({tag, ".addr"}, dmem_addr_o, 32'd0);
        chk({tag, ".be"}, 32'(dmem_be_o), 32'd0);
        chk({tag, ".wdata"}, dmem_wdata_o, 32'd0);
        chk({tag, ".data_o"}, data_o, 32'd0);
        chk({tag, ".rd_o"}, 32'(rd_o), 32'd0);
        chk({tag, ".reg_write_o"}, 32'(reg_write_o), 32'd0);
        chk({tag, ".fault_o"}, 32'(fault_o), 32'd0);
        chk({tag, ".instruction_o"}, instruction_o, 32'd0);
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
        valid_i = 1'b1; load_i = ld; store_i = st; funct3_i = f3;
        alu_result_i = a; store_data_i = sd; rd_i = rd; reg_write_i = !st;
        instruction_i = {a[15:0], 11'd0, rd};
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; load_i = 1'b0; store_i = 1'b0;
    endtask

    // Memory op with gw cycles of gnt wait and rw cycles of rvalid wait.
    // xbe/xwd/xaddr/xdata/xlat are hand-computed expectations.
    task automatic mem_op(input string nm, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input int gw, input int rw, input logic [31:0] rdata,
                          input logic [3:0] xbe, input logic [31:0] xwd, input logic [31:0] xaddr,
                          input logic [31:0] xdata, input int xlat);
        int  acc;
        bit  got;
        drive_op(!st, st, f3, a, sd, rd);
        step();
        acc = cyc;
        idle_inputs();
        for (int i = 0; i <= gw; i++) begin
            chk({nm, ".req"}, 32'(dmem_req_o), 32'd1);
            chk({nm, ".addr"}, dmem_addr_o, xaddr);
            chk({nm, ".be"}, 32'(dmem_be_o), 32'(xbe));
            if (st) chk({nm, ".wdata"}, dmem_wdata_o, xwd);
            // a stray response while still requesting must be ignored
            dmem_rvalid_i = (i == 0) && (gw > 0);
            dmem_rdata_i  = 32'hDEAD_BEEF;
            dmem_gnt_i    = (i == gw);
            step();
        end
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        if (!st) begin
            for (int i = 0; i < rw; i++) step();
            dmem_rdata_i = rdata; dmem_rvalid_i = 1'b1;
            step();
            dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (valid_o) begin
                got = 1'b1;
                chk({nm, ".latency"}, 32'(cyc - acc + 1), 32'(xlat));
                chk({nm, ".reg_write_o"}, 32'(reg_write_o), 32'(!st));
                chk({nm, ".fault_o"}, 32'(fault_o), 32'd0);
                if (!st) chk({nm, ".data_o"}, data_o, xdata);
            end else begin
                step();
            end
        end
        if (!got) chk({nm, ".valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic fault_op(input string nm, input logic st, input logic [2:0] f3, input logic [31:0] a);
        drive_op(!st, st, f3, a, 32'h5555_5555, 5'd9);
        step();
        idle_inputs();
        chk({nm, ".valid_o"}, 32'(valid_o), 32'd1);
        chk({nm, ".fault_o"}, 32'(fault_o), 32'd1);
        chk({nm, ".reg_write_o"}, 32'(reg_write_o), 32'd0);
        chk({nm, ".data_o"}, data_o, a);
        chk({nm, ".req"}, 32'(dmem_req_o), 32'd0);
        chk({nm, ".ready_o"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] alu_vals [3];
        alu_vals[0] = 32'h11; alu_vals[1] = 32'h22; alu_vals[2] = 32'h33;
        rst_i = 1'b1; idle_inputs(); funct3_i = 3'd0; alu_result_i = 32'd0;
        store_data_i = 32'd0; rd_i = 5'd0; reg_write_i = 1'b0; instruction_i = 32'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
        step(); step();
        rst_i = 1'b0;
        step();
        dmem_rvalid_i = 1'b0;
        check_reset_outputs("reset");

        // ALU pass-through, back to back
        for (int k = 0; k < 3; k++) begin
            drive_op(1'b0, 1'b0, 3'd0, alu_vals[k], 32'd0, 5'(k + 1));
            step();
            chk("alu.valid_o", 32'(valid_o), 32'd1);
            chk("alu.data_o", data_o, alu_vals[k]);
            chk("alu.rd_o", 32'(rd_o), 32'(k + 1));
            chk("alu.ready_o", 32'(ready_o), 32'd1);
        end
        idle_inputs();
        step();
        chk("alu.single_pulse", 32'(valid_o), 32'd0);

        // Stores
        mem_op("sb", 1'b1, 3'b000, 32'h1002, 32'hAABB_CCDD, 5'd4, 2, 0, 32'd0,
               4'b0100, 32'hDDDD_DDDD, 32'h1000, 32'd0, 4);
        mem_op("sh", 1'b1, 3'b001, 32'h1006, 32'h1234_5678, 5'd5, 0, 0, 32'd0,
               4'b1100, 32'h5678_5678, 32'h1004, 32'd0, 2);
        mem_op("sw", 1'b1, 3'b010, 32'h1008, 32'hCAFE_F00D, 5'd6, 1, 0, 32'd0,
               4'b1111, 32'hCAFE_F00D, 32'h1008, 32'd0, 3);

        // Loads
        mem_op("lb", 1'b0, 3'b000, 32'h2003, 32'd0, 5'd7, 0, 0, 32'h80F0_7F01,
               4'b0000, 32'd0, 32'h2000, 32'hFFFF_FF80, 3);
        mem_op("lhu", 1'b0, 3'b101, 32'h2002, 32'd0, 5'd8, 1, 2, 32'h80F0_7F01,
               4'b0000, 32'd0, 32'h2000, 32'h0000_80F0, 6);
        mem_op("lw", 1'b0, 3'b010, 32'h2000, 32'd0, 5'd10, 0, 0, 32'h80F0_7F01,
               4'b0000, 32'd0, 32'h2000, 32'h80F0_7F01, 3);
        mem_op("lh", 1'b0, 3'b001, 32'h2000, 32'd0, 5'd11, 0, 1, 32'h80F0_7F01,
               4'b0000, 32'd0, 32'h2000, 32'h0000_7F01, 4);
        mem_op("lbu", 1'b0, 3'b100, 32'h2001, 32'd0, 5'd12, 0, 0, 32'h80F0_7F01,
               4'b0000, 32'd0, 32'h2000, 32'h0000_007F, 3);
        mem_op("lh_neg", 1'b0, 3'b001, 32'h2002, 32'd0, 5'd13, 0, 0, 32'h80F0_7F01,
               4'b0000, 32'd0, 32'h2000, 32'hFFFF_80F0, 3);

        // Faults
        fault_op("lw_mis", 1'b0, 3'b010, 32'h3001);
        fault_op("sh_mis", 1'b1, 3'b001, 32'h1001);
        fault_op("st_f3", 1'b1, 3'b100, 32'h4000);
        fault_op("ld_f3", 1'b0, 3'b110, 32'h4000);

        // Reset while waiting for load data, then a stale response
        drive_op(1'b1, 1'b0, 3'b010, 32'h2000, 32'd0, 5'd14);
        step();
        idle_inputs();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_reset_outputs("rst_mid");
        dmem_rdata_i = 32'h0BAD_0BAD; dmem_rvalid_i = 1'b1;
        step();
        dmem_rvalid_i = 1'b0;
        check_reset_outputs("rst_stale");
        step();
        chk("rst_after.valid_o", 32'(valid_o), 32'd0);

        // Pass-through still works after the abandoned transaction
        drive_op(1'b0, 1'b0, 3'd0, 32'h77, 32'd0, 5'd15);
        step();
        idle_inputs();
        chk("post_rst.data_o", data_o, 32'h77);
        chk("post_rst.rd_o", 32'(rd_o), 32'd15);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/memstage.md
# memstage

Memory-access stage of the rv32i pipeline, sitting between execute and writeback. It accepts one executed instruction at a time and issues loads and stores to the data memory over a request/grant/rvalid handshake. It aligns and extends load data, then presents a one-cycle-valid result (register index, write enable, write data) to the writeback stage. Non-memory instructions pass straight through with one cycle of latency.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  execute stage presents an instruction.
- ready_o  out  1  stage can accept; the instruction is accepted when valid_i && ready_o.
- instruction_i  in  riscv_pkg::instruction_t  instruction, carried through unmodified.
- alu_result_i  in  32  ALU result, or effective address for load/store.
- store_data_i  in  32  rs2 value for stores.
- load_i  in  1  instruction is a load.
- store_i  in  1  instruction is a store; load_i and store_i are never both high.
- funct3_i  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- rd_i  in  5  destination register.
- reg_write_i  in  1  instruction writes rd.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_be_o  out  4  byte enables (stores; 4'b0000 for loads).
- dmem_wdata_o  out  32  store data, lane-replicated.
- dmem_gnt_i  in  1  memory accepts the request this cycle.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data word.
- valid_o  out  1  one-cycle pulse: result fields are valid for writeback.
- instruction_o  out  riscv_pkg::instruction_t  registered copy of the accepted instruction.
- data_o  out  32  writeback data.
- rd_o  out  5  destination register.
- reg_write_o  out  1  writeback enable; forced to 0 on a fault and for stores.
- fault_o  out  1  misaligned access or illegal funct3; qualified by valid_o.

## Operation
- FSM states:
  - **IDLE**: ready_o=1.
  - **REQ**: ready_o=0, dmem_req_o=1.
  - **WAIT**: ready_o=0, waiting for load data.
- **IDLE, instruction accepted:**
  - Non-memory op: next cycle valid_o=1, data_o=alu_result_i, rd_o/reg_write_o/instruction_o registered from the inputs. Stay in IDLE.
  - Memory op with a fault: next cycle valid_o=1, fault_o=1, reg_write_o=0, data_o=alu_result_i (faulting address). No memory request. Stay in IDLE.
  - Fault conditions:
    - Half access with addr[0]=1.
    - Word access with addr[1:0]≠0.
    - Store with funct3 ∉ {000,001,010}.
    - Load with funct3 ∉ {000,001,010,100,101}.
  - Valid memory op: latch op, address, data, funct3, rd, reg_write and instruction. Go to REQ.
- **REQ:** dmem_req_o=1 with dmem_we_o, dmem_addr_o, dmem_be_o and dmem_wdata_o driven from latched values. These are held stable until dmem_gnt_i.
  - Store granted: next cycle valid_o=1, reg_write_o=0; go to IDLE.
  - Load granted: go to WAIT.
  - dmem_rvalid_i is ignored in REQ.
- **WAIT:** on dmem_rvalid_i, next cycle valid_o=1, data_o=formatted load data, reg_write_o=latched value. Go to IDLE.
- **Store formatting:**
  - SB: be = 4'b0001<<addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: be = 1111, wdata = data.
- **Load formatting:**
  - Byte: select byte addr[1:0]. Half: select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- dmem_rvalid_i in IDLE (e.g. a stale response after reset) is ignored.

## Timing
- **Reset values:** state=IDLE, valid_o=0, fault_o=0, reg_write_o=0, rd_o=0, data_o=0, instruction_o='0, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0.
- **Latency** (accept in cycle N):
  - Non-memory op or fault: valid_o at N+1.
  - Store: earliest valid_o at N+2 (gnt at N+1).
  - Load: earliest valid_o at N+3 (gnt at N+1, rvalid at N+2).
  - Each wait cycle on gnt or rvalid adds one cycle.
- **Throughput:** back-to-back non-memory ops at 1 per cycle. A new instruction can be accepted in the same cycle valid_o is high if the state is IDLE.
- valid_o is high for exactly one cycle per accepted instruction. Result fields hold their values until the next update.
- reset asserted mid-transaction (REQ/WAIT): next cycle is IDLE with all outputs at reset values; the outstanding request is abandoned.

## Test plan
- **ALU pass-through:** 3 back-to-back non-memory ops with alu_result 0x11, 0x22, 0x33 and rd 1, 2, 3 -> valid_o at N+1..N+3 with matching data_o/rd_o; ready_o stays 1.
- **SB:** store_data 0xAABBCCDD, addr 0x1002, gnt held low 2 cycles -> dmem_be_o=0100, dmem_wdata_o=0xDDDDDDDD, dmem_addr_o=0x1000 stable until gnt; valid_o with reg_write_o=0 one cycle after gnt.
- **LB / LHU:** rdata 0x80F0_7F01:
  - LB @ addr 0x2003 -> data_o=0xFFFFFF80.
  - LHU @ addr 0x2002 -> data_o=0x000080F0.
  - LW -> 0x80F07F01.
- **Misaligned:** LW @ 0x3001 -> no dmem_req_o; valid_o at N+1 with fault_o=1, reg_write_o=0, data_o=0x3001.
- **Reset mid-load:** reset in WAIT, then dmem_rvalid_i pulses after release -> outputs at reset values, no valid_o, ready_o=1.
- **Zero-wait load:** gnt in the first REQ cycle, rvalid the next -> valid_o exactly 3 cycles after acceptance.
